// File: rtl/vga_line_prefetch.sv
// Prefetches the next scanout line from the shared single-port framebuffer into a
// 2-line buffer and grants renderer accesses between fetch beats. Optional: VGA_LPF_UNDERRUN_EN.
module vga_line_prefetch #(
    parameter int ADDR_W   = 19,
    parameter int FB_BASE  = 0,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int CPU_SLOT = 8
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic [9:0]        Line,
    output logic              lb_we,
    output logic [10:0]       lb_addr,
    output logic [7:0]        lb_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
`ifdef VGA_LPF_UNDERRUN_EN
    output logic              underrun,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, F_REQ, F_WAIT, C_REQ, C_WAIT} state_t;

    localparam int                SLOT_W    = $clog2(CPU_SLOT + 1);
    localparam logic [9:0]        LAST_LINE = 10'(V_TOTAL - 1);
    localparam logic [9:0]        V_LIMIT   = 10'(V_ACTIVE);
    localparam logic [9:0]        LAST_PX   = 10'(H_ACTIVE - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(CPU_SLOT);

    state_t              state_q, state_d;
    logic [9:0]          line_q;
    logic [9:0]          t_q, t_d, t_next;
    logic [9:0]          px_q, px_d;
    logic [SLOT_W-1:0]   slot_q, slot_d, slot_inc;
    logic                discard_q, discard_d;
    logic                cap_we_q, cap_we_d;
    logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
    logic [7:0]          cap_wdata_q, cap_wdata_d;
    logic                trigger, fetch_go;

    logic                busy_d, mem_req_d, mem_we_d, lb_we_d, cpu_ack_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [7:0]          mem_wdata_d, lb_wdata_d, cpu_rdata_d;
    logic [10:0]         lb_addr_d;

    // Line T starts at T*640 = (T<<9)+(T<<7), wrapping within the address space.
    function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] t);
        return ADDR_W'(FB_BASE) + (ADDR_W'(t) << 9) + (ADDR_W'(t) << 7);
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latches are inferred.
        trigger     = (Line != line_q);
        t_next      = (Line == LAST_LINE) ? 10'd0 : Line + 10'd1;
        fetch_go    = trigger && (t_next < V_LIMIT);
        slot_inc    = (slot_q == SLOT_MAX) ? slot_q : slot_q + 1'b1;

        state_d     = state_q;
        t_d         = t_q;
        px_d        = px_q;
        slot_d      = slot_q;
        discard_d   = discard_q;
        cap_we_d    = cap_we_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        busy_d      = busy;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        lb_we_d     = 1'b0;
        lb_addr_d   = lb_addr;
        lb_wdata_d  = lb_wdata;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata;

        // A new line while already working: restart the fetch for the new target and
        // drop the data of a read that is still in flight.
        if (fetch_go && state_q != IDLE) begin
            t_d    = t_next;
            px_d   = '0;
            busy_d = 1'b1;
            if (state_q == F_WAIT)
                discard_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fetch_go) begin
                    state_d = F_REQ;
                    t_d     = t_next;
                    px_d    = '0;
                    slot_d  = '0;
                    busy_d  = 1'b1;
                end else if (cpu_req) begin
                    state_d     = C_REQ;
                    cap_we_d    = cpu_we;
                    cap_addr_d  = cpu_addr;
                    cap_wdata_d = cpu_wdata;
                end
            end
            F_REQ: begin
                if (!fetch_go) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_base(t_q) + ADDR_W'(px_q);
                    state_d    = F_WAIT;
                end
            end
            F_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    slot_d    = slot_inc;
                    if (!discard_q && !fetch_go) begin
                        lb_we_d    = 1'b1;
                        lb_addr_d  = {t_q[0], px_q};
                        lb_wdata_d = mem_rdata;
                        px_d       = px_q + 10'd1;
                    end
                    if (!discard_q && !fetch_go && px_q == LAST_PX) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else if (slot_inc == SLOT_MAX && cpu_req) begin
                        state_d     = C_REQ;
                        slot_d      = '0;
                        cap_we_d    = cpu_we;
                        cap_addr_d  = cpu_addr;
                        cap_wdata_d = cpu_wdata;
                    end else begin
                        state_d = F_REQ;
                    end
                end
            end
            C_REQ: begin
                mem_req_d   = 1'b1;
                mem_we_d    = cap_we_q;
                mem_addr_d  = cap_addr_q;
                mem_wdata_d = cap_wdata_q;
                state_d     = C_WAIT;
            end
            C_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    cpu_ack_d = 1'b1;
                    if (!cap_we_q)
                        cpu_rdata_d = mem_rdata;
                    state_d = busy_d ? F_REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            line_q      <= '0;
            t_q         <= '0;
            px_q        <= '0;
            slot_q      <= '0;
            discard_q   <= 1'b0;
            cap_we_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            lb_we       <= 1'b0;
            lb_addr     <= '0;
            lb_wdata    <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            line_q      <= Line;
            t_q         <= t_d;
            px_q        <= px_d;
            slot_q      <= slot_d;
            discard_q   <= discard_d;
            cap_we_q    <= cap_we_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            busy        <= busy_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            lb_we       <= lb_we_d;
            lb_addr     <= lb_addr_d;
            lb_wdata    <= lb_wdata_d;
            cpu_ack     <= cpu_ack_d;
            cpu_rdata   <= cpu_rdata_d;
        end
    end

`ifdef VGA_LPF_UNDERRUN_EN
    // Sticky: scanout moved on before the previous prefetch finished.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst)
            underrun <= 1'b0;
        else if (trigger && busy)
            underrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Self-checking bench for vga_line_prefetch: line-step vector table, renderer
// interleave, overrun restart and async reset, with memory/line-buffer scoreboards.
module tb_vga_line_prefetch;
    localparam int ADDR_W = 19;

    logic              clk100 = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        Line = '0;
    logic              lb_we;
    logic [10:0]       lb_addr;
    logic [7:0]        lb_wdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [7:0]        cpu_wdata = '0;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack, busy;
`ifdef VGA_LPF_UNDERRUN_EN
    logic              underrun;
`endif

    vga_line_prefetch dut (
        .clk100(clk100), .rst(rst), .Line(Line),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
`ifdef VGA_LPF_UNDERRUN_EN
        .underrun(underrun),
`endif
        .busy(busy)
    );

    always #5 clk100 = ~clk100;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } mem_txn_t;

    typedef struct {
        int from_line;
        int to_line;
        int exp_reads;
        int exp_base;
        int exp_lb0;
    } row_t;

    mem_txn_t          exp_mem[$];
    logic [18:0]       exp_lb[$];
    int                n_checks = 0, n_errors = 0;
    int                lat = 0, wait_cnt = 0;
    int                n_mem = 0, n_lb = 0, n_ack = 0;
    logic [7:0]        last_cpu_rdata = '0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [7:0]        last_wr_data = '0;
    mem_txn_t          e_txn;
    logic [18:0]       e_lb;

    function automatic logic [7:0] data_of(input logic [ADDR_W-1:0] a);
        logic [23:0] w;
        w = 24'(a);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: acks a held request after 'lat' waiting cycles and scores it.
    always @(negedge clk100) begin
        mem_ack = 1'b0;
        if (rst || !mem_req) begin
            wait_cnt = 0;
        end else if (wait_cnt < lat) begin
            wait_cnt++;
        end else begin
            wait_cnt  = 0;
            mem_ack   = 1'b1;
            mem_rdata = data_of(mem_addr);
            n_mem++;
            if (mem_we) begin
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
            end
            if (exp_mem.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mem_unexpected: got we=%0d addr=0x%0h, expected no transaction", mem_we, mem_addr);
            end else begin
                e_txn = exp_mem.pop_front();
                check("mem_txn", {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00},
                      {e_txn.we, e_txn.addr, e_txn.we ? e_txn.wdata : 8'h00});
            end
        end
    end

    // Line-buffer and renderer-ack monitor.
    always @(negedge clk100) begin
        if (lb_we) begin
            n_lb++;
            if (exp_lb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL lb_unexpected: got addr=0x%0h data=0x%0h, expected no write", lb_addr, lb_wdata);
            end else begin
                e_lb = exp_lb.pop_front();
                check("lb_write", {lb_addr, lb_wdata}, e_lb);
            end
        end
        if (cpu_ack) begin
            n_ack++;
            last_cpu_rdata = cpu_rdata;
        end
    end

    task automatic tick();
        @(negedge clk100);
        #1;
    endtask

    task automatic push_reads(input logic [ADDR_W-1:0] base, input int p0, input int p1);
        mem_txn_t t;
        for (int p = p0; p <= p1; p++) begin
            t.we    = 1'b0;
            t.addr  = base + ADDR_W'(p);
            t.wdata = 8'h00;
            exp_mem.push_back(t);
        end
    endtask

    task automatic push_lb(input logic [ADDR_W-1:0] base, input logic [10:0] lb0, input int p0, input int p1);
        for (int p = p0; p <= p1; p++)
            exp_lb.push_back({lb0 + 11'(p), data_of(base + ADDR_W'(p))});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) tick();
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        check({name, "_done"}, busy, 1'b0);
        repeat (4) tick();
    endtask

    task automatic check_drained(input string name);
        check({name, "_drained"}, exp_mem.size() + exp_lb.size(), 0);
    endtask

    // Reference model for stepping to a line: target, base address and buffer half.
    task automatic step_model(input logic [9:0] l);
        logic [9:0]        t;
        logic [ADDR_W-1:0] base;
        t    = (l == 10'd524) ? 10'd0 : l + 10'd1;
        base = ADDR_W'(int'(t) * 640);
        if (t < 10'd480) begin
            push_reads(base, 0, 639);
            push_lb(base, {t[0], 10'd0}, 0, 639);
        end
        Line = l;
        wait_idle("step");
        check_drained("step");
    endtask

    initial begin
        row_t              rows[5];
        int                n0, a0, n;
        mem_txn_t          wr;

        rows[0] = '{9,   10,  640, 7040,   'h400};
        rows[1] = '{477, 478, 640, 306560, 'h400};
        rows[2] = '{479, 480, 0,   0,      'h000};
        rows[3] = '{523, 524, 640, 0,      'h000};
        rows[4] = '{524, 0,   640, 640,    'h400};

        #1;
        check("reset_outputs", {lb_we, lb_addr, lb_wdata, mem_req, mem_we, mem_addr, mem_wdata,
                                cpu_rdata, cpu_ack, busy}, '0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        check("post_reset_idle", {busy, mem_req, lb_we}, 3'b000);

        // Line-step vector table
        for (int i = 0; i < 5; i++) begin
            if (Line != 10'(rows[i].from_line))
                step_model(10'(rows[i].from_line));
            n0 = n_mem;
            if (rows[i].exp_reads != 0) begin
                push_reads(ADDR_W'(rows[i].exp_base), 0, 639);
                push_lb(ADDR_W'(rows[i].exp_base), 11'(rows[i].exp_lb0), 0, 639);
            end
            Line = 10'(rows[i].to_line);
            tick();
            tick();
            check($sformatf("row%0d_busy", i), busy, rows[i].exp_reads != 0);
            wait_idle($sformatf("row%0d", i));
            check($sformatf("row%0d_reads", i), n_mem - n0, rows[i].exp_reads);
            check_drained($sformatf("row%0d", i));
        end

        // Renderer write held during a fetch: served after the 8th beat, fetch resumes at px=8
        push_reads(ADDR_W'(1280), 0, 7);
        wr.we = 1'b1;
        wr.addr = 19'h12345;
        wr.wdata = 8'hA5;
        exp_mem.push_back(wr);
        push_reads(ADDR_W'(1280), 8, 639);
        push_lb(ADDR_W'(1280), 11'h000, 0, 639);
        a0 = n_ack;
        cpu_we = 1'b1;
        cpu_addr = 19'h12345;
        cpu_wdata = 8'hA5;
        cpu_req = 1'b1;
        Line = 10'd1;
        n = 0;
        repeat (3) tick();
        while ((busy || cpu_req) && n < 20000) begin
            tick();
            n++;
            if (n_ack != a0)
                cpu_req = 1'b0;
        end
        repeat (4) tick();
        check("cpu_wr_acks", n_ack - a0, 1);
        check("cpu_wr_mem", {last_wr_addr, last_wr_data}, {19'h12345, 8'hA5});
        check("cpu_wr_busy", busy, 1'b0);
        check_drained("cpu_wr");

        // Renderer read from IDLE
        wr.we = 1'b0;
        wr.addr = 19'h00777;
        wr.wdata = 8'h00;
        exp_mem.push_back(wr);
        a0 = n_ack;
        cpu_we = 1'b0;
        cpu_addr = 19'h00777;
        cpu_req = 1'b1;
        tick();
        tick();
        check("cpu_rd_req_latency", mem_req, 1'b1);
        n = 0;
        while (n_ack == a0 && n < 50) begin
            tick();
            n++;
        end
        cpu_req = 1'b0;
        repeat (4) tick();
        check("cpu_rd_acks", n_ack - a0, 1);
        check("cpu_rd_data", last_cpu_rdata, data_of(19'h00777));
        check_drained("cpu_rd");

        // Overrun: slow memory, line changes while beat 100 is outstanding
        step_model(10'd30);
        lat = 10;
        push_reads(ADDR_W'(20480), 0, 100);
        push_lb(ADDR_W'(20480), 11'h000, 0, 99);
        push_reads(ADDR_W'(21120), 0, 639);
        push_lb(ADDR_W'(21120), 11'h400, 0, 639);
        Line = 10'd31;
        n = 0;
        while (!(mem_req && mem_addr == ADDR_W'(20580)) && n < 5000) begin
            tick();
            n++;
        end
        check("ovr_reach_beat100", mem_addr, 20580);
`ifdef VGA_LPF_UNDERRUN_EN
        check("underrun_before", underrun, 1'b0);
`endif
        Line = 10'd32;
        wait_idle("ovr");
        check_drained("ovr");
`ifdef VGA_LPF_UNDERRUN_EN
        check("underrun_after", underrun, 1'b1);
`endif

        // Async reset in the middle of a slow fetch beat
        push_reads(ADDR_W'(26240), 0, 639);
        push_lb(ADDR_W'(26240), 11'h400, 0, 639);
        n0 = n_mem;
        Line = 10'd40;
        n = 0;
        while (n_mem - n0 < 3 && n < 2000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("rst_pre_req", {mem_req, busy}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {lb_we, lb_addr, lb_wdata, mem_req, mem_we, mem_addr, mem_wdata,
                                    cpu_rdata, cpu_ack, busy}, '0);
        exp_mem.delete();
        exp_lb.delete();
        Line = 10'd0;
        lat = 0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("rst_release_idle", {busy, mem_req}, 2'b00);
        n0 = n_mem;
        step_model(10'd5);
        check("rst_refetch_reads", n_mem - n0, 640);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
